// File: rtl/coinc_acq_ctrl.sv
// coinc_acq_ctrl: acquisition sequencer (clear, gate, settle, snapshot, drain).
// Define COINC_ACQ_CONTINUOUS_EN to rerun measurements back-to-back until Stop.
module coinc_acq_ctrl #(
    parameter  int NCHAN   = 5,
    parameter  int NBITS   = 6,
    localparam int NPAIRS  = NCHAN*(NCHAN-1)/2,
    parameter  int WBITS   = 16,
    parameter  int NSETTLE = 4
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          Start,
    input  logic                          Stop,
    input  logic [WBITS-1:0]              Window,
    input  logic [NPAIRS-1:0][NBITS-1:0]  Counts,
    output logic                          DetClr,
    output logic                          DetEn,
    output logic                          Busy,
    output logic                          OutValid,
    input  logic                          OutReady,
    output logic [NBITS-1:0]              OutData,
    output logic [$clog2(NPAIRS)-1:0]     OutIdx,
    output logic                          OutLast,
    output logic                          Done
);

    localparam int IW = $clog2(NPAIRS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NPAIRS-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COUNT,
        S_SETTLE,
        S_SNAP,
        S_DRAIN
    } state_t;

`ifdef COINC_ACQ_CONTINUOUS_EN
    localparam state_t S_AFTER = S_CLEAR;
`else
    localparam state_t S_AFTER = S_IDLE;
`endif

    state_t                       state_q, state_d;
    logic [WBITS-1:0]             win_q, win_d;
    logic [WBITS-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [NPAIRS-1:0][NBITS-1:0] shadow_q, shadow_d;
    logic                         done_q, done_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            win_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
        end
    end

    // One down-counter serves both the gate window and the settle flush.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    win_d   = Window;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (win_q == '0) begin
                    cnt_d   = WBITS'(NSETTLE);
                    state_d = S_SETTLE;
                end else begin
                    cnt_d   = win_q;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == WBITS'(1)) begin
                    cnt_d   = WBITS'(NSETTLE);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == WBITS'(1)) begin
                    state_d = S_SNAP;
                end
            end
            S_SNAP: begin
                shadow_d = Counts;
                idx_d    = '0;
                state_d  = S_DRAIN;
            end
            S_DRAIN: begin
                if (OutReady) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_AFTER;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (Stop) begin
            state_d = S_IDLE;
            win_d   = win_q;
            done_d  = 1'b0;
        end
    end

    assign DetClr   = (state_q == S_CLEAR);
    assign DetEn    = (state_q == S_COUNT);
    assign Busy     = (state_q != S_IDLE);
    assign OutValid = (state_q == S_DRAIN);
    assign OutData  = shadow_q[idx_q];
    assign OutIdx   = idx_q;
    assign OutLast  = OutValid && (idx_q == LAST_IDX);
    assign Done     = done_q;

endmodule
